// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters; all outputs registered.
// Optional WAIT-state timeout is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_scheduler #(
    parameter int OP_W    = 2,
    parameter int DATA_W  = 3,
    parameter int RES_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              ClockA,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [OP_W-1:0]   op0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic [1:0]        ack,
    output logic [RES_W-1:0]  result,
    output logic [OP_W-1:0]   last_op,
    output logic              err,
    output logic              busy,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   rr;
    logic   id;
    logic   winner;
    logic   timeout_hit;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge ClockA) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        winner     = req[1];
        if (req == 2'b11) begin
            winner = rr;
        end
        case (state)
            IDLE:    if (req != 2'b00) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (alu_done || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ClockA) begin
        if (Reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            id        <= 1'b0;
            ack       <= 2'b00;
            result    <= '0;
            last_op   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            alu_start <= (next_state == ISSUE);
            ack       <= (next_state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        id     <= winner;
                        alu_op <= winner ? op1 : op0;
                        alu_a  <= winner ? a1 : a0;
                        alu_b  <= winner ? b1 : b0;
                    end
                end
                WAIT: begin
                    // A done arriving on the limit cycle wins over the timeout.
                    if (alu_done) begin
                        result  <= alu_result;
                        last_op <= alu_op;
                        err     <= 1'b0;
                    end else if (timeout_hit) begin
                        result  <= '0;
                        last_op <= alu_op;
                        err     <= 1'b1;
                    end
                end
                RESP: begin
                    rr  <= ~id;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
